// File: rtl/int_issue_queue_pkg.sv
// Shared issue-queue types: uop entry layout and ROB age comparison.
package int_issue_queue_pkg;

  localparam int PREG_W        = 6;
  localparam int SRC_W         = 64;
  localparam int CX_TYPE_W     = 3;
  localparam int ALU_TYPE_W    = 4;
  localparam int MULDIV_TYPE_W = 3;
  localparam int PC_W          = 64;
  localparam int ROB_W         = 5;

  typedef struct packed {
    logic [PREG_W-1:0]        prd;
    logic [PREG_W-1:0]        prs1;
    logic [PREG_W-1:0]        prs2;
    logic [SRC_W-1:0]         imm;
    logic                     need_to_wb;
    logic [CX_TYPE_W-1:0]     cx_type;
    logic                     is_unsigned;
    logic [ALU_TYPE_W-1:0]    alu_type;
    logic                     is_word;
    logic                     is_imm;
    logic [MULDIV_TYPE_W-1:0] muldiv_type;
    logic [PC_W-1:0]          pc;
    logic                     robidx_flag;
    logic [ROB_W-1:0]         robidx;
    logic                     src1_rdy;
    logic                     src2_rdy;
  } iq_entry_t;

  // a is older than b; a flag mismatch means b has wrapped past the ROB end
  function automatic logic rob_older(input logic a_flag, input logic [ROB_W-1:0] a_idx,
                                     input logic b_flag, input logic [ROB_W-1:0] b_idx);
    return (a_flag == b_flag) ? (a_idx < b_idx) : (a_idx > b_idx);
  endfunction

endpackage

// File: rtl/int_issue_queue_if.sv
// Dispatch / wakeup / issue bundle of the integer issue queue.
interface int_issue_queue_if
  import int_issue_queue_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int NUM_WAKEUP = 2
) ();
  localparam int IDX_W = $clog2(DEPTH);

  logic                     enq_valid;
  logic                     enq_ready;
  logic [PREG_W-1:0]        enq_prd, enq_prs1, enq_prs2;
  logic                     enq_src1_ready, enq_src2_ready;
  logic [SRC_W-1:0]         enq_imm;
  logic                     enq_need_to_wb, enq_is_unsigned, enq_is_word, enq_is_imm;
  logic [CX_TYPE_W-1:0]     enq_cx_type;
  logic [ALU_TYPE_W-1:0]    enq_alu_type;
  logic [MULDIV_TYPE_W-1:0] enq_muldiv_type;
  logic [PC_W-1:0]          enq_pc;
  logic                     enq_robidx_flag;
  logic [ROB_W-1:0]         enq_robidx;

  logic [NUM_WAKEUP-1:0]             wb_valid;
  logic [NUM_WAKEUP-1:0][PREG_W-1:0] wb_prd;
  logic                              flush_valid;

  logic                     out_instr_valid;
  logic                     out_instr_ready;
  logic [PREG_W-1:0]        out_prd, out_prs1, out_prs2;
  logic [SRC_W-1:0]         out_imm;
  logic                     out_need_to_wb, out_is_unsigned, out_is_word, out_is_imm;
  logic [CX_TYPE_W-1:0]     out_cx_type;
  logic [ALU_TYPE_W-1:0]    out_alu_type;
  logic [MULDIV_TYPE_W-1:0] out_muldiv_type;
  logic [PC_W-1:0]          out_pc;
  logic                     out_robidx_flag;
  logic [ROB_W-1:0]         out_robidx;
  logic [IDX_W:0]           count;

  modport master (
    output enq_valid, enq_prd, enq_prs1, enq_prs2, enq_src1_ready, enq_src2_ready, enq_imm,
           enq_need_to_wb, enq_is_unsigned, enq_is_word, enq_is_imm, enq_cx_type,
           enq_alu_type, enq_muldiv_type, enq_pc, enq_robidx_flag, enq_robidx,
           wb_valid, wb_prd, flush_valid, out_instr_ready,
    input  enq_ready, out_instr_valid, out_prd, out_prs1, out_prs2, out_imm, out_need_to_wb,
           out_cx_type, out_is_unsigned, out_alu_type, out_is_word, out_is_imm,
           out_muldiv_type, out_pc, out_robidx_flag, out_robidx, count
  );

  modport slave (
    input  enq_valid, enq_prd, enq_prs1, enq_prs2, enq_src1_ready, enq_src2_ready, enq_imm,
           enq_need_to_wb, enq_is_unsigned, enq_is_word, enq_is_imm, enq_cx_type,
           enq_alu_type, enq_muldiv_type, enq_pc, enq_robidx_flag, enq_robidx,
           wb_valid, wb_prd, flush_valid, out_instr_ready,
    output enq_ready, out_instr_valid, out_prd, out_prs1, out_prs2, out_imm, out_need_to_wb,
           out_cx_type, out_is_unsigned, out_alu_type, out_is_word, out_is_imm,
           out_muldiv_type, out_pc, out_robidx_flag, out_robidx, count
  );
endinterface

// File: rtl/int_issue_queue_age_select.sv
// Oldest-ready selector: one-hot grant to the ready entry no other ready entry is older than.
module iq_age_select
  import int_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]            rdy_i,
  input  logic [DEPTH-1:0]            flag_i,
  input  logic [DEPTH-1:0][ROB_W-1:0] idx_i,
  output logic [DEPTH-1:0]            grant_o,
  output logic                        valid_o
);

  assign valid_o = |rdy_i;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    // entry wins unless some other ready entry is older (ROB positions are unique)
    always_comb begin
      grant_o[gi] = rdy_i[gi];
      for (int j = 0; j < DEPTH; j++)
        if (j != gi && rdy_i[j] && rob_older(flag_i[j], idx_i[j], flag_i[gi], idx_i[gi]))
          grant_o[gi] = 1'b0;
    end
  end

endmodule

// File: rtl/int_issue_queue.sv
// Integer out-of-order issue queue: holds renamed uops until both sources are
// woken, issues the oldest ready one per cycle, clears everything on redirect.
module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int NUM_WAKEUP = 2
) (
  input  logic              clock,
  input  logic              reset,
  int_issue_queue_if.slave  io
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]            vld_q, vld_d;
  iq_entry_t [DEPTH-1:0]       ent_q, ent_d;
  logic [IDX_W:0]              cnt_q, cnt_d;

  logic [IDX_W-1:0]            free_idx, sel_idx;
  logic [DEPTH-1:0]            cand, grant, flag_v;
  logic [DEPTH-1:0][ROB_W-1:0] idx_v;
  logic                        sel_any, enq_fire, issue_fire;
  iq_entry_t                   enq_ent, sel_ent;

  function automatic logic wb_hit(input logic [PREG_W-1:0] p,
                                  input logic [NUM_WAKEUP-1:0] v,
                                  input logic [NUM_WAKEUP-1:0][PREG_W-1:0] prd);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WAKEUP; k++)
      if (v[k] && prd[k] == p) hit = 1'b1;
    return hit;
  endfunction

  // lowest-index free slot for enqueue
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!vld_q[i]) free_idx = IDX_W'(i);
  end

  // candidates use registered ready bits only, so a wakeup issues the cycle after its edge
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cand[i]   = vld_q[i] & ent_q[i].src1_rdy & ent_q[i].src2_rdy;
      flag_v[i] = ent_q[i].robidx_flag;
      idx_v[i]  = ent_q[i].robidx;
    end
  end

  iq_age_select #(.DEPTH(DEPTH)) u_sel (
    .rdy_i   (cand),
    .flag_i  (flag_v),
    .idx_i   (idx_v),
    .grant_o (grant),
    .valid_o (sel_any)
  );

  // one-hot grant to index; defaults to entry 0 when nothing is selected
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (grant[i]) sel_idx = IDX_W'(i);
  end

  assign sel_ent    = ent_q[sel_idx];
  assign io.enq_ready       = (cnt_q != (IDX_W+1)'(DEPTH));
  assign io.out_instr_valid = sel_any & ~io.flush_valid;
  assign enq_fire   = io.enq_valid & io.enq_ready & ~io.flush_valid;
  assign issue_fire = io.out_instr_valid & io.out_instr_ready;

  // incoming entry; sources woken in the same cycle are captured as ready
  always_comb begin
    enq_ent             = '0;
    enq_ent.prd         = io.enq_prd;
    enq_ent.prs1        = io.enq_prs1;
    enq_ent.prs2        = io.enq_prs2;
    enq_ent.imm         = io.enq_imm;
    enq_ent.need_to_wb  = io.enq_need_to_wb;
    enq_ent.cx_type     = io.enq_cx_type;
    enq_ent.is_unsigned = io.enq_is_unsigned;
    enq_ent.alu_type    = io.enq_alu_type;
    enq_ent.is_word     = io.enq_is_word;
    enq_ent.is_imm      = io.enq_is_imm;
    enq_ent.muldiv_type = io.enq_muldiv_type;
    enq_ent.pc          = io.enq_pc;
    enq_ent.robidx_flag = io.enq_robidx_flag;
    enq_ent.robidx      = io.enq_robidx;
    enq_ent.src1_rdy    = io.enq_src1_ready | (io.enq_prs1 == '0) |
                          wb_hit(io.enq_prs1, io.wb_valid, io.wb_prd);
    enq_ent.src2_rdy    = io.enq_src2_ready | (io.enq_prs2 == '0) |
                          wb_hit(io.enq_prs2, io.wb_valid, io.wb_prd);
  end

  // next state: wakeup, issue clear, enqueue fill, flush override
  always_comb begin
    vld_d = vld_q;
    ent_d = ent_q;
    cnt_d = cnt_q + (IDX_W+1)'(enq_fire) - (IDX_W+1)'(issue_fire);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && wb_hit(ent_q[i].prs1, io.wb_valid, io.wb_prd)) ent_d[i].src1_rdy = 1'b1;
      if (vld_q[i] && wb_hit(ent_q[i].prs2, io.wb_valid, io.wb_prd)) ent_d[i].src2_rdy = 1'b1;
    end
    if (issue_fire) vld_d[sel_idx] = 1'b0;
    if (enq_fire) begin
      vld_d[free_idx] = 1'b1;
      ent_d[free_idx] = enq_ent;
    end
    if (io.flush_valid) begin
      vld_d = '0;
      cnt_d = '0;
    end
  end

  // state registers; reset clears payload too so idle outputs read zero
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign io.count           = cnt_q;
  assign io.out_prd         = sel_ent.prd;
  assign io.out_prs1        = sel_ent.prs1;
  assign io.out_prs2        = sel_ent.prs2;
  assign io.out_imm         = sel_ent.imm;
  assign io.out_need_to_wb  = sel_ent.need_to_wb;
  assign io.out_cx_type     = sel_ent.cx_type;
  assign io.out_is_unsigned = sel_ent.is_unsigned;
  assign io.out_alu_type    = sel_ent.alu_type;
  assign io.out_is_word     = sel_ent.is_word;
  assign io.out_is_imm      = sel_ent.is_imm;
  assign io.out_muldiv_type = sel_ent.muldiv_type;
  assign io.out_pc          = sel_ent.pc;
  assign io.out_robidx_flag = sel_ent.robidx_flag;
  assign io.out_robidx      = sel_ent.robidx;

endmodule

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- Out-of-order issue queue that feeds the integer execution block: it is the producer side of that block's instr_valid/instr_ready issue interface.
- Accepts renamed integer uops from dispatch, one per cycle, and holds them until both physical sources are ready.
- Tracks source readiness by snooping writeback wakeups, including the integer block's own out_instr_valid/out_need_to_wb/out_prd.
- Issues the oldest ready uop (ROB order) each cycle to register read / intblock; flushes everything on redirect.

Parameters:
- DEPTH, 8, number of queue entries (power of 2, ≥2).
- IDX_W, $clog2(DEPTH), entry index width.
- NUM_WAKEUP, 2, number of writeback wakeup ports (port 0 = intblock, port 1 = memblock).

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enq_valid  in  1  dispatch offers a uop.
- enq_ready  out  1  queue can accept this cycle.
- enq_prd, enq_prs1, enq_prs2  in  `PREG_RANGE each  destination and source physical registers.
- enq_src1_ready, enq_src2_ready  in  1 each  source already available at dispatch.
- enq_imm  in  `SRC_RANGE  immediate.
- enq_need_to_wb, enq_is_unsigned, enq_is_word, enq_is_imm  in  1 each  control bits.
- enq_cx_type, enq_alu_type, enq_muldiv_type  in  `CX_TYPE_RANGE / `ALU_TYPE_RANGE / `MULDIV_TYPE_RANGE  op class.
- enq_pc  in  `PC_RANGE  pc.
- enq_robidx_flag, enq_robidx  in  1 / `ROB_SIZE_LOG  ROB position.
- wb_valid  in  NUM_WAKEUP  wakeup valid (valid & need_to_wb already ANDed).
- wb_prd  in  NUM_WAKEUP x `PREG_RANGE  woken physical register.
- flush_valid  in  1  redirect; discard all entries.
- out_instr_valid  out  1  issue valid.
- out_instr_ready  in  1  downstream accepts.
- out_prd, out_prs1, out_prs2, out_imm, out_need_to_wb, out_cx_type, out_is_unsigned, out_alu_type, out_is_word, out_is_imm, out_muldiv_type, out_pc, out_robidx_flag, out_robidx  out  same widths as the enq_ fields  issued uop.
- count  out  IDX_W+1  occupied entries (perf/debug).

Behaviour:
- Storage: DEPTH entries, each holding valid, src1_rdy, src2_rdy and all uop fields. Any free slot may be filled; the lowest-index free slot is used.
- Reset: all entry valid=0, count=0. Consequently out_instr_valid=0 and enq_ready=1. Payload outputs are don't-care while out_instr_valid=0 but are driven from entry 0 (zero after reset).
- enq_ready = (count != DEPTH). No same-cycle issue bypass into a full queue.
- Enqueue on enq_valid & enq_ready & !flush_valid. Entry src_rdy = enq_srcN_ready | (prsN == 0) | any wb_valid[k] & wb_prd[k]==prsN in the same cycle.
- Wakeup: every valid entry whose prsN matches a valid wb_prd sets srcN_rdy at the next edge. An entry woken at edge t becomes issuable in cycle t (registered ready; no combinational wakeup-to-issue path).
- Select: candidates are entries with valid & src1_rdy & src2_rdy. Pick the oldest by ROB age: older(a,b) = (a.flag==b.flag) ? a.idx<b.idx : a.idx>b.idx. Issue outputs are combinational from the selected entry.
- out_instr_valid = any candidate & !flush_valid.
- Issue handshake: on out_instr_valid & out_instr_ready the selected entry is cleared at the edge. While out_instr_ready=0 the outputs may change if an older uop becomes ready; no hold requirement, because intblock is always ready.
- count(next) = count + enq_fire − issue_fire. Enqueue and issue in the same cycle leave count unchanged.
- flush_valid: at the edge all entries become valid=0 and count=0. Same-cycle enqueue and issue are suppressed, and wakeups that cycle are irrelevant.
- Reset asserted mid-operation behaves identically to flush and has priority over all other events.
- Robidx wrap-around is handled by the flag rule. Live entries never span more than one ROB lap.

Decomposition:
- Shared package: an iq_entry_t struct holding the uop fields plus ready bits, and the rob_older() age-compare function, reused by the memory issue queue.
- One sub-module: iq_age_select, a DEPTH-wide oldest-ready selector (ready vector + robidx array -> one-hot grant + valid). Kept separate so it can be unit-tested and replaced by an age matrix later.

Test Plan:
- Reset, then enqueue an add with both sources ready (robidx=3) -> out_instr_valid next cycle with out_robidx=3, count returns to 0 after issue.
- Enqueue uop A (prs1=7, not ready), then uop B (ready); pulse wb_valid[0] with wb_prd=7 -> B issues first, A issues the cycle after the wakeup edge.
- Enqueue robidx flag=1/idx=1 and flag=0/idx=30, both ready -> flag=0/idx=30 issues first (wrap-around ordering).
- Fill 8 entries with src1 not ready -> enq_ready=0 at count=8; wake prs1 -> one issue per cycle, enq_ready=1 once count=7.
- Enqueue with enq_prs1 equal to a same-cycle wb_prd and src1_ready=0 -> entry issuable on the next cycle (bypass at enqueue).
- Queue holding 5 entries, assert flush_valid together with enq_valid -> count=0 next cycle, no issue, enqueued uop dropped.
